ocl_xor_regs: RTL

//  AXI4-Lite responder terminating the registered OCL (BAR0) path of the XOR CL (after the AXI-Lite register slice).

---
 rtl/ocl_xor_regs.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ocl_xor_regs.sv
// AXI4-Lite responder for the XOR CL OCL path: operands OPA/OPB, their XOR, an ID word and a counter.
// Define OCL_XOR_CNT_EN to build the RESULT-read access counter at 0x0C; otherwise 0x0C reads 0.
module ocl_xor_regs #(
   parameter int unsigned ADDR_W   = 32,
   parameter logic [31:0] ID_VALUE = 32'h1D51_FEDD,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic              clk_main_a0,
   input  logic              rst_main,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wstrb,
   input  logic              wvalid,
   output logic              wready,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic [ADDR_W-1:0] araddr,
   input  logic              arvalid,
   output logic              arready,
   output logic [31:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rvalid,
   input  logic              rready
);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} wrState_e;
   typedef enum logic {R_IDLE, R_DATA} rdState_e;

   wrState_e          wrState_q, wrState_d;
   rdState_e          rdState_q, rdState_d;
   logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
   logic              arready_q, arready_d, rvalid_q, rvalid_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [ADDR_W-1:2] wAddr_q, wAddr_d;
   logic [31:0]       wData_q, wData_d;
   logic [3:0]        wStrb_q, wStrb_d;
   logic [31:0]       opA_q, opA_d, opB_q, opB_d;
   logic [31:0]       cntValue;

   logic              awFire, wFire, arFire, bFire, rFire, commit;
   logic [ADDR_W-1:2] cWord;
   logic [31:0]       cData, rdVal;
   logic [3:0]        cStrb;
   logic [2:0]        cIdx, rIdx;
   logic              cMapped, rMapped;
   logic [3:0]        unusedAddrBits;

   assign unusedAddrBits = {awaddr[1:0], araddr[1:0]};

   assign awFire = awvalid && awready_q;
   assign wFire  = wvalid && wready_q;
   assign arFire = arvalid && arready_q;
   assign bFire  = bvalid_q && bready;
   assign rFire  = rvalid_q && rready;

   // Whichever half arrived first was latched; the other comes straight from the bus.
   assign cWord   = (wrState_q == W_WAIT_W) ? wAddr_q : awaddr[ADDR_W-1:2];
   assign cData   = (wrState_q == W_WAIT_AW) ? wData_q : wdata;
   assign cStrb   = (wrState_q == W_WAIT_AW) ? wStrb_q : wstrb;
   assign cIdx    = cWord[4:2];
   assign cMapped = (cWord[ADDR_W-1:5] == '0) && (cIdx <= 3'd4);
   assign commit  = ((wrState_q == W_IDLE) && awFire && wFire) ||
                    ((wrState_q == W_WAIT_W) && wFire) ||
                    ((wrState_q == W_WAIT_AW) && awFire);

   assign rIdx    = araddr[4:2];
   assign rMapped = (araddr[ADDR_W-1:5] == '0) && (rIdx <= 3'd4);

`ifdef OCL_XOR_CNT_EN
   logic [31:0] cnt_q;
   logic        cntClear;

   // Clearing by a write wins over a RESULT read accepted in the same cycle.
   always_ff @(posedge clk_main_a0 or posedge rst_main) begin
      if (rst_main) cnt_q <= '0;
      else if (cntClear) cnt_q <= '0;
      else if (arFire && rMapped && (rIdx == 3'd2)) cnt_q <= cnt_q + 32'd1;
   end
   assign cntValue = cnt_q;
`else
   assign cntValue = '0;
`endif

   // Write channel: address/data may arrive in either order; the commit happens when both are present.
   always_comb begin
      wrState_d = wrState_q;
      wAddr_d   = wAddr_q;
      wData_d   = wData_q;
      wStrb_d   = wStrb_q;
      bresp_d   = bresp_q;
      opA_d     = opA_q;
      opB_d     = opB_q;
`ifdef OCL_XOR_CNT_EN
      cntClear  = 1'b0;
`endif
      case (wrState_q)
         W_IDLE: begin
            if (awFire && wFire) wrState_d = W_RESP;
            else if (awFire) begin
               wAddr_d   = awaddr[ADDR_W-1:2];
               wrState_d = W_WAIT_W;
            end else if (wFire) begin
               wData_d   = wdata;
               wStrb_d   = wstrb;
               wrState_d = W_WAIT_AW;
            end
         end
         W_WAIT_W:  if (wFire) wrState_d = W_RESP;
         W_WAIT_AW: if (awFire) wrState_d = W_RESP;
         W_RESP:    if (bFire) wrState_d = W_IDLE;
         default:   wrState_d = W_IDLE;
      endcase
      if (commit) begin
         bresp_d = RESP_SLVERR;
         if (cMapped && (cIdx == 3'd0)) begin
            bresp_d = RESP_OKAY;
            for (int i = 0; i < 4; i++) if (cStrb[i]) opA_d[8*i +: 8] = cData[8*i +: 8];
         end else if (cMapped && (cIdx == 3'd1)) begin
            bresp_d = RESP_OKAY;
            for (int i = 0; i < 4; i++) if (cStrb[i]) opB_d[8*i +: 8] = cData[8*i +: 8];
         end
`ifdef OCL_XOR_CNT_EN
         else if (cMapped && (cIdx == 3'd3)) cntClear = 1'b1;
`endif
      end
      awready_d = (wrState_d == W_IDLE) || (wrState_d == W_WAIT_AW);
      wready_d  = (wrState_d == W_IDLE) || (wrState_d == W_WAIT_W);
      bvalid_d  = (wrState_d == W_RESP);
   end

   // Read channel: data is captured at address accept, so a same-cycle write is not yet visible.
   always_comb begin
      rdState_d = rdState_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (rIdx)
         3'd0:    rdVal = opA_q;
         3'd1:    rdVal = opB_q;
         3'd2:    rdVal = opA_q ^ opB_q;
         3'd3:    rdVal = cntValue;
         3'd4:    rdVal = ID_VALUE;
         default: rdVal = '0;
      endcase
      case (rdState_q)
         R_IDLE: if (arFire) begin
            rdState_d = R_DATA;
            rdata_d   = rMapped ? rdVal : ERR_DATA;
            rresp_d   = rMapped ? RESP_OKAY : RESP_SLVERR;
         end
         R_DATA:  if (rFire) rdState_d = R_IDLE;
         default: rdState_d = R_IDLE;
      endcase
      arready_d = (rdState_d == R_IDLE);
      rvalid_d  = (rdState_d == R_DATA);
   end

   always_ff @(posedge clk_main_a0 or posedge rst_main) begin
      if (rst_main) begin
         wrState_q <= W_IDLE;
         rdState_q <= R_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         wAddr_q   <= '0;
         wData_q   <= '0;
         wStrb_q   <= '0;
         opA_q     <= '0;
         opB_q     <= '0;
      end else begin
         wrState_q <= wrState_d;
         rdState_q <= rdState_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         wAddr_q   <= wAddr_d;
         wData_q   <= wData_d;
         wStrb_q   <= wStrb_d;
         opA_q     <= opA_d;
         opB_q     <= opB_d;
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
endmodule
